nqueen_solver: RTL and testbench

- Parametrised N-queens backtracking engine: controller and board datapath in one block.
- Places one queen per row on an N×N board with an internal per-row column store, checks safety one previous queen per cycle, and backtracks on exhaustion.
- Two modes: stop at the first solution, or enumerate all solutions and count them.
- Sits behind the board/display logic; the host starts it, waits for done/no_answer, then reads the board through the read port.

---
 rtl/nqueen_solver.sv | 137 +++++++++++++
 tb/tb_nqueen_solver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nqueen_solver.sv
// nqueen_solver: N-queens backtracking engine.
// One queen per row, columns held in pos[]. Safety is checked against one
// earlier row per cycle, and the search backtracks when a row runs out of
// columns. It can stop at the first solution or count every solution.
module nqueen_solver #(
    parameter int N       = 8,
    parameter int COL_W   = 3,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               user_reset,
    input  logic               start,
    input  logic               mode,
    output logic               ready,
    output logic               sol_found,
    output logic               done,
    output logic               no_answer,
    output logic [COUNT_W-1:0] solution_count,
    input  logic [COL_W-1:0]   read_row,
    output logic [COL_W-1:0]   read_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_PLACE,
        S_FOUND,
        S_ADVANCE,
        S_BACKTRACK,
        S_FINISH
    } state_t;

    localparam logic [COL_W-1:0] LAST = COL_W'(N - 1);

    state_t                    state, state_nxt;
    logic [N-1:0][COL_W-1:0]   pos;
    logic [COL_W-1:0]          r, c, k;
    logic                      mode_q;
    logic [COUNT_W-1:0]        count;

    logic [COL_W-1:0]          pos_k;
    logic [COL_W:0]            col_diff, row_diff;
    logic                      conflict;

    // Attack test between the candidate (r,c) and the queen in row k.
    // The widened, ordered subtraction gives |pos[k]-c| without wrap-around.
    always_comb begin
        pos_k    = pos[k];
        col_diff = (pos_k >= c) ? ({1'b0, pos_k} - {1'b0, c})
                                : ({1'b0, c} - {1'b0, pos_k});
        row_diff = {1'b0, r} - {1'b0, k};
        conflict = (pos_k == c) || (col_diff == row_diff);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (user_reset) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_INIT;
            S_INIT:      state_nxt = S_CHECK;
            S_CHECK: begin
                if (k == r)        state_nxt = S_PLACE;
                else if (conflict) state_nxt = S_ADVANCE;
            end
            S_PLACE:     state_nxt = (r == LAST) ? S_FOUND : S_CHECK;
            S_FOUND:     state_nxt = mode_q ? S_ADVANCE : S_FINISH;
            S_ADVANCE:   state_nxt = (c == LAST) ? S_BACKTRACK : S_CHECK;
            S_BACKTRACK: state_nxt = (r == '0) ? S_FINISH : S_ADVANCE;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Board datapath: row/column/check cursors, column store, counter.
    always_ff @(posedge clk) begin
        if (user_reset) begin
            pos    <= '0;
            r      <= '0;
            c      <= '0;
            k      <= '0;
            mode_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) mode_q <= mode;
                S_INIT: begin
                    r     <= '0;
                    c     <= '0;
                    k     <= '0;
                    count <= '0;
                end
                S_CHECK: if (k != r && !conflict) k <= k + COL_W'(1);
                S_PLACE: begin
                    pos[r] <= c;
                    if (r != LAST) begin
                        r <= r + COL_W'(1);
                        c <= '0;
                        k <= '0;
                    end
                end
                S_FOUND: if (count != '1) count <= count + COUNT_W'(1);
                S_ADVANCE: begin
                    if (c != LAST) begin
                        c <= c + COL_W'(1);
                        k <= '0;
                    end
                end
                S_BACKTRACK: begin
                    // Resume the previous row from the column it held.
                    if (r != '0) begin
                        r <= r - COL_W'(1);
                        c <= pos[r - COL_W'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from state (FINISH splits on the final count).
    always_comb begin
        ready          = (state == S_IDLE);
        sol_found      = (state == S_FOUND);
        done           = (state == S_FINISH) && (count != '0);
        no_answer      = (state == S_FINISH) && (count == '0);
        solution_count = count;
        read_col       = (int'(read_row) < N) ? pos[read_row] : '0;
    end

endmodule

// File: tb/tb_nqueen_solver.sv
// tb_nqueen_solver: directed checks on several board sizes, one instance per size.
module tb_nqueen_solver;

    localparam int NI    = 6;
    localparam int LIMIT = 90000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [NI];
    logic        start_v [NI];
    logic        mode_v  [NI];
    logic [3:0]  rrow_v  [NI];
    logic        ready_v [NI];
    logic        sol_v   [NI];
    logic        done_v  [NI];
    logic        na_v    [NI];
    logic [15:0] cnt_v   [NI];
    logic [3:0]  rcol_v  [NI];

    int checks   = 0;
    int failures = 0;

    // 0: N=4   1: N=8   2: N=8 COUNT_W=4   3: N=3   4: N=2   5: N=8 (start-noise run)
    logic [1:0] rc0, rc3;
    logic [2:0] rc1, rc2, rc5;
    logic [0:0] rc4;
    logic [3:0] cnt2;

    nqueen_solver #(.N(4), .COL_W(2), .COUNT_W(16)) u0 (
        .clk(clk), .user_reset(rst_v[0]), .start(start_v[0]), .mode(mode_v[0]),
        .ready(ready_v[0]), .sol_found(sol_v[0]), .done(done_v[0]), .no_answer(na_v[0]),
        .solution_count(cnt_v[0]), .read_row(rrow_v[0][1:0]), .read_col(rc0));
    nqueen_solver #(.N(8), .COL_W(3), .COUNT_W(16)) u1 (
        .clk(clk), .user_reset(rst_v[1]), .start(start_v[1]), .mode(mode_v[1]),
        .ready(ready_v[1]), .sol_found(sol_v[1]), .done(done_v[1]), .no_answer(na_v[1]),
        .solution_count(cnt_v[1]), .read_row(rrow_v[1][2:0]), .read_col(rc1));
    nqueen_solver #(.N(8), .COL_W(3), .COUNT_W(4)) u2 (
        .clk(clk), .user_reset(rst_v[2]), .start(start_v[2]), .mode(mode_v[2]),
        .ready(ready_v[2]), .sol_found(sol_v[2]), .done(done_v[2]), .no_answer(na_v[2]),
        .solution_count(cnt2), .read_row(rrow_v[2][2:0]), .read_col(rc2));
    nqueen_solver #(.N(3), .COL_W(2), .COUNT_W(16)) u3 (
        .clk(clk), .user_reset(rst_v[3]), .start(start_v[3]), .mode(mode_v[3]),
        .ready(ready_v[3]), .sol_found(sol_v[3]), .done(done_v[3]), .no_answer(na_v[3]),
        .solution_count(cnt_v[3]), .read_row(rrow_v[3][1:0]), .read_col(rc3));
    nqueen_solver #(.N(2), .COL_W(1), .COUNT_W(16)) u4 (
        .clk(clk), .user_reset(rst_v[4]), .start(start_v[4]), .mode(mode_v[4]),
        .ready(ready_v[4]), .sol_found(sol_v[4]), .done(done_v[4]), .no_answer(na_v[4]),
        .solution_count(cnt_v[4]), .read_row(rrow_v[4][0:0]), .read_col(rc4));
    nqueen_solver #(.N(8), .COL_W(3), .COUNT_W(16)) u5 (
        .clk(clk), .user_reset(rst_v[5]), .start(start_v[5]), .mode(mode_v[5]),
        .ready(ready_v[5]), .sol_found(sol_v[5]), .done(done_v[5]), .no_answer(na_v[5]),
        .solution_count(cnt_v[5]), .read_row(rrow_v[5][2:0]), .read_col(rc5));

    assign rcol_v[0] = {2'b0, rc0};
    assign rcol_v[1] = {1'b0, rc1};
    assign rcol_v[2] = {1'b0, rc2};
    assign rcol_v[3] = {2'b0, rc3};
    assign rcol_v[4] = {3'b0, rc4};
    assign rcol_v[5] = {1'b0, rc5};
    assign cnt_v[2]  = {12'b0, cnt2};

    typedef struct {
        int          idx;
        bit          m;
        int          exp_pulses;
        bit          exp_done;
        int          exp_count;
        int          nb;      // rows of the board to check afterwards
        logic [31:0] board;   // row i expected column in nibble i
    } run_t;

    run_t runs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One search on instance idx; optionally sprays start/mode while it runs.
    task automatic run_search(input int idx, input bit m, input bit noisy,
                              input int exp_pulses, input bit exp_done, input int exp_count);
        int  pulses   = 0;
        int  cyc      = 0;
        int  last_sol = -10;
        bit  ended    = 0;
        @(negedge clk);
        mode_v[idx]  = m;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        mode_v[idx]  = ~m;
        chk($sformatf("ready_low[%0d]", idx), int'(ready_v[idx]), 0);
        while (cyc < LIMIT) begin
            if (sol_v[idx]) begin
                pulses++;
                last_sol = cyc;
            end
            if (idx == 2 && pulses == 15 && cyc == last_sol + 1)
                chk("sat_after_15", int'(cnt_v[idx]), 15);
            if (done_v[idx] || na_v[idx]) begin
                ended = 1;
                break;
            end
            if (noisy) begin
                start_v[idx] = ((cyc % 41) == 0);
                mode_v[idx]  = ((cyc % 2) == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start_v[idx] = 1'b0;
        chk($sformatf("finished[%0d]", idx), int'(ended), 1);
        chk($sformatf("pulses[%0d]", idx), pulses, exp_pulses);
        chk($sformatf("done[%0d]", idx), int'(done_v[idx]), int'(exp_done));
        chk($sformatf("no_answer[%0d]", idx), int'(na_v[idx]), int'(!exp_done));
        chk($sformatf("count[%0d]", idx), int'(cnt_v[idx]), exp_count);
        if (!m && exp_done)
            chk($sformatf("sol_to_done[%0d]", idx), cyc - last_sol, 1);
        @(negedge clk);
        chk($sformatf("ready_back[%0d]", idx), int'(ready_v[idx]), 1);
        chk($sformatf("end_pulse_gone[%0d]", idx), int'(done_v[idx] | na_v[idx]), 0);
    endtask

    initial begin
        logic [31:0] bd;
        int          w;
        bit          quiet;

        runs[0] = '{0, 1'b0, 1, 1'b1, 1, 4, 32'h0000_2031};
        runs[1] = '{0, 1'b1, 2, 1'b1, 2, 0, 32'h0};
        runs[2] = '{1, 1'b0, 1, 1'b1, 1, 8, 32'h3162_5740};
        runs[3] = '{3, 1'b1, 0, 1'b0, 0, 0, 32'h0};
        runs[4] = '{3, 1'b0, 0, 1'b0, 0, 0, 32'h0};
        runs[5] = '{4, 1'b1, 0, 1'b0, 0, 0, 32'h0};

        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; mode_v[i] = 1'b0; rrow_v[i] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state.
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_ready[%0d]", i), int'(ready_v[i]), 1);
            chk($sformatf("rst_pulses[%0d]", i), int'(sol_v[i] | done_v[i] | na_v[i]), 0);
            chk($sformatf("rst_count[%0d]", i), int'(cnt_v[i]), 0);
        end
        for (int j = 0; j < 8; j++) begin
            rrow_v[1] = 4'(j);
            #1;
            chk($sformatf("rst_pos[%0d]", j), int'(rcol_v[1]), 0);
        end
        for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;

        // Table of single searches, board read-back where the answer is defined.
        for (int i = 0; i < 6; i++) begin
            run_search(runs[i].idx, runs[i].m, 1'b0, runs[i].exp_pulses,
                       runs[i].exp_done, runs[i].exp_count);
            bd = runs[i].board;
            for (int j = 0; j < runs[i].nb; j++) begin
                rrow_v[runs[i].idx] = 4'(j);
                #1;
                chk($sformatf("board[%0d][%0d]", runs[i].idx, j),
                    int'(rcol_v[runs[i].idx]), int'(bd[4*j +: 4]));
            end
        end

        // Reset during an enumeration on N=8, after the first solution.
        @(negedge clk);
        mode_v[1] = 1'b1; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        w = 0;
        while (!sol_v[1] && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("mid_first_sol_seen", int'(sol_v[1]), 1);
        repeat (3) @(negedge clk);
        chk("mid_count_before", int'(cnt_v[1]), 1);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        chk("mid_ready", int'(ready_v[1]), 1);
        chk("mid_count", int'(cnt_v[1]), 0);
        chk("mid_no_end", int'(done_v[1] | na_v[1]), 0);
        quiet = 1;
        repeat (5) begin
            @(negedge clk);
            if (done_v[1] || na_v[1] || !ready_v[1]) quiet = 0;
        end
        chk("mid_stays_idle", int'(quiet), 1);

        // Full N=8 enumerations run side by side.
        fork
            run_search(1, 1'b1, 1'b0, 92, 1'b1, 92);
            run_search(2, 1'b1, 1'b0, 92, 1'b1, 15);
            run_search(5, 1'b1, 1'b1, 92, 1'b1, 92);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
